pulse_burst_controller: RTL and testbench

- Programmable pulse scheduler. Accepts one burst configuration per job over a valid/ready handshake: period, high width, pulse count and start delay.
- Sequences a pulse train with those settings, then reports completion.
- Sits above the fixed-interval pulse generators. Intended driver is a CSR block or a test sequencer.

---
 rtl/pulse_ctrl_pkg.sv | 20 ++
 rtl/pulse_phase_counter.sv | 31 +++
 rtl/pulse_burst_controller.sv | 132 +++++++++++++
 tb/tb_pulse_burst_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_ctrl_pkg.sv
// Shared types and clamp helpers for the pulse burst controller.
package pulse_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, DELAY, HIGH, LOW, DONE} state_e;

  localparam int unsigned MIN_PERIOD = 2;
  localparam int unsigned MIN_WIDTH  = 1;

  function automatic int unsigned clamp_period(input int unsigned p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  // Width must leave at least one low cycle inside the (already clamped) period.
  function automatic int unsigned clamp_width(input int unsigned w, input int unsigned p_eff);
    if (w < MIN_WIDTH) return MIN_WIDTH;
    if (w > p_eff - 1) return p_eff - 1;
    return w;
  endfunction

endpackage

// File: rtl/pulse_phase_counter.sv
// Loadable down-counter timing one phase; expire_o is a registered (count==1) flag.
module pulse_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_value_i,
  input  logic             enable_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q;
  logic             expire_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else if (load_i) begin
      count_q  <= load_value_i;
      expire_q <= (load_value_i == CNT_W'(1));
    end else if (enable_i && count_q != '0) begin
      count_q  <= count_q - CNT_W'(1);
      expire_q <= (count_q == CNT_W'(2));
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/pulse_burst_controller.sv
// Programmable pulse burst scheduler: period/width/count/delay per job, done strobe at end.
module pulse_burst_controller
  import pulse_ctrl_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_width,
  input  logic [BURST_W-1:0] cfg_count,
  input  logic [CNT_W-1:0]   cfg_delay,
  input  logic               stop,
  output logic               pulse,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_count
);

  state_e             state_q;
  logic [CNT_W-1:0]   period_q, width_q;
  logic [BURST_W-1:0] burst_q, pulse_count_q;
  logic               pulse_q, done_q;

  logic [CNT_W-1:0]   p_in, w_in;
  logic               ph_load, ph_en, ph_expire;
  logic [CNT_W-1:0]   ph_value;
  logic               last_pulse;

  assign p_in = CNT_W'(clamp_period(32'(cfg_period)));
  assign w_in = CNT_W'(clamp_width(32'(cfg_width), 32'(p_in)));

  // Continuous mode (count 0) never reaches a last pulse.
  assign last_pulse = (burst_q != '0) && (pulse_count_q == burst_q);

  always_comb begin
    ph_load  = 1'b0;
    ph_en    = 1'b0;
    ph_value = '0;
    case (state_q)
      IDLE: if (cfg_valid) begin
        ph_load  = 1'b1;
        ph_value = (cfg_delay != '0) ? cfg_delay : w_in;
      end
      DELAY, LOW: if (!stop) begin
        if (ph_expire) begin
          ph_load  = 1'b1;
          ph_value = width_q;
        end else ph_en = 1'b1;
      end
      HIGH: if (!stop) begin
        if (ph_expire) begin
          ph_load  = !last_pulse;
          ph_value = period_q - width_q;
        end else ph_en = 1'b1;
      end
      default: ;
    endcase
  end

  pulse_phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk          (clk),
    .rst          (rst),
    .load_i       (ph_load),
    .load_value_i (ph_value),
    .enable_i     (ph_en),
    .expire_o     (ph_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      period_q      <= '0;
      width_q       <= '0;
      burst_q       <= '0;
      pulse_count_q <= '0;
      pulse_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cfg_valid) begin
          period_q <= p_in;
          width_q  <= w_in;
          burst_q  <= cfg_count;
          if (cfg_delay != '0) begin
            state_q       <= DELAY;
            pulse_count_q <= '0;
          end else begin
            state_q       <= HIGH;
            pulse_q       <= 1'b1;
            pulse_count_q <= BURST_W'(1);
          end
        end
        DELAY, LOW: begin
          if (stop) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (ph_expire) begin
            state_q       <= HIGH;
            pulse_q       <= 1'b1;
            pulse_count_q <= pulse_count_q + BURST_W'(1);
          end
        end
        HIGH: begin
          if (stop || (ph_expire && last_pulse)) begin
            state_q <= DONE;
            pulse_q <= 1'b0;
            done_q  <= 1'b1;
          end else if (ph_expire) begin
            state_q <= LOW;
            pulse_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pulse       = pulse_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign cfg_ready   = (state_q == IDLE);
  assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_pulse_burst_controller.sv
// Bench for pulse_burst_controller: table-driven bursts with a per-cycle scoreboard plus corner sequences.
module tb_pulse_burst_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0, stop = 1'b0;
  logic [7:0] cfg_period = '0, cfg_width = '0, cfg_delay = '0, cfg_count = '0;
  logic       cfg_ready, pulse, busy, done;
  logic [7:0] pulse_count;

  always #5 clk = ~clk;

  pulse_burst_controller #(.CNT_W(8), .BURST_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_count(cfg_count),
    .cfg_delay(cfg_delay), .stop(stop), .pulse(pulse), .busy(busy),
    .done(done), .pulse_count(pulse_count)
  );

  // p/w/n/d: raw config; first/hi/per/done_c: hand-derived effective timing.
  typedef struct {
    int p, w, n, d;
    int first, hi, per, done_c;
  } vec_t;

  typedef struct packed {
    logic       pulse, done, busy, ready;
    logic [7:0] pcnt;
  } obs_t;

  obs_t exp_q[$];
  vec_t vecs[7];
  int   errors = 0, checks = 0;

  function automatic obs_t observe();
    obs_t o;
    o = {pulse, done, busy, cfg_ready, pulse_count};
    return o;
  endfunction

  function automatic obs_t mk(logic p, logic d, logic b, logic r, int cnt);
    obs_t o;
    o = {p, d, b, r, 8'(cnt)};
    return o;
  endfunction

  // Expected outputs in cycle c after the accept edge.
  function automatic obs_t model(vec_t v, int c);
    obs_t o;
    int   k;
    o.busy  = (c <= v.done_c);
    o.ready = !o.busy;
    o.done  = (c == v.done_c);
    k = (c < v.first) ? 0 : ((c - v.first) / v.per + 1);
    if (k > v.n) k = v.n;
    o.pcnt  = 8'(k);
    o.pulse = (c >= v.first) && (c < v.done_c) && (((c - v.first) % v.per) < v.hi);
    return o;
  endfunction

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got pulse=%b done=%b busy=%b ready=%b cnt=%0d expected pulse=%b done=%b busy=%b ready=%b cnt=%0d",
               name, got.pulse, got.done, got.busy, got.ready, got.pcnt,
               exp.pulse, exp.done, exp.busy, exp.ready, exp.pcnt);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive_cfg(input vec_t v);
    cfg_period = 8'(v.p);
    cfg_width  = 8'(v.w);
    cfg_count  = 8'(v.n);
    cfg_delay  = 8'(v.d);
    cfg_valid  = 1'b1;
  endtask

  // Starts at a negedge in IDLE; ends at the negedge of cycle done_c+1 (IDLE again).
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive_cfg(v);
    for (int c = 1; c <= v.done_c + 1; c++) exp_q.push_back(model(v, c));
    @(posedge clk);
    for (int c = 1; c <= v.done_c + 1; c++) begin
      @(negedge clk);
      chk($sformatf("vec%0d c%0d", idx, c), observe(), exp_q.pop_front());
      cfg_valid = 1'b0;
    end
  endtask

  initial begin
    vec_t v;
    int   npulses;

    vecs[0] = '{10, 1, 3, 0,  1, 1, 10, 22};
    vecs[1] = '{ 6, 4, 2, 5,  6, 4,  6, 16};
    vecs[2] = '{ 0, 0, 4, 0,  1, 1,  2,  8};
    vecs[3] = '{ 5, 9, 2, 0,  1, 4,  5, 10};
    vecs[4] = '{ 2, 1, 1, 1,  2, 1,  2,  3};
    vecs[5] = '{ 4, 0, 3, 3,  4, 1,  4, 13};
    vecs[6] = '{ 3, 3, 1, 0,  1, 2,  3,  3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", observe(), mk(0, 0, 0, 1, 0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Continuous mode, stop during the 300th pulse.
    @(negedge clk);
    v = '{3, 1, 0, 0, 1, 1, 3, 0};
    drive_cfg(v);
    npulses = 0;
    @(posedge clk);
    for (int c = 1; c <= 898; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      if (pulse) npulses++;
      if (c == 766) chk("cont wrap", observe(), mk(1, 0, 1, 0, 0));
      if (c == 898) begin
        chk("cont p300", observe(), mk(1, 0, 1, 0, 44));
        stop = 1'b1;
      end
    end
    @(negedge clk);
    chk("cont stop", observe(), mk(0, 1, 1, 0, 44));
    chk_int("cont npulses", npulses, 300);
    stop = 1'b0;
    @(negedge clk);
    chk("cont idle", observe(), mk(0, 0, 0, 1, 44));

    // Stop during DELAY: no pulse, done next cycle.
    @(negedge clk);
    v = '{4, 2, 3, 5, 0, 0, 0, 0};
    drive_cfg(v);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("dstop c1", observe(), mk(0, 0, 1, 0, 0));
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    chk("dstop c3", observe(), mk(0, 1, 1, 0, 0));
    stop = 1'b0;
    @(negedge clk);
    chk("dstop c4", observe(), mk(0, 0, 0, 1, 0));

    // Stop together with accept in IDLE: the burst starts.
    @(negedge clk);
    v = '{4, 2, 1, 0, 0, 0, 0, 0};
    drive_cfg(v);
    stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("sacc c1", observe(), mk(1, 0, 1, 0, 1));
    cfg_valid = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    chk("sacc c2", observe(), mk(1, 0, 1, 0, 1));
    @(negedge clk);
    chk("sacc c3", observe(), mk(0, 1, 1, 0, 1));
    @(negedge clk);
    chk("sacc c4", observe(), mk(0, 0, 0, 1, 1));

    // cfg_valid held through a burst: next accept only after DONE.
    @(negedge clk);
    v = '{2, 1, 2, 0, 1, 1, 2, 4};
    drive_cfg(v);
    for (int c = 1; c <= 5; c++) exp_q.push_back(model(v, c));
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold c%0d", c), observe(), exp_q.pop_front());
    end
    for (int c = 7; c <= 10; c++) exp_q.push_back(model(v, c - 5));
    @(negedge clk);
    chk("hold c6", observe(), mk(1, 0, 1, 0, 1));
    cfg_valid = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("hold c%0d", c), observe(), exp_q.pop_front());
    end

    // Reset during LOW of pulse 2 of 5.
    @(negedge clk);
    v = '{4, 1, 5, 0, 0, 0, 0, 0};
    drive_cfg(v);
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
    end
    chk("rst pre", observe(), mk(0, 0, 1, 0, 2));
    rst = 1'b1;
    @(negedge clk);
    chk("rst post", observe(), mk(0, 0, 0, 1, 0));
    rst = 1'b0;
    run_vec(vecs[0], 10);

    chk_int("scoreboard empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
